// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared widths, depth and FSM state type for data_memory.
package data_memory_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DEPTH      = 256;
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous write and combinational read.
// Optional even-parity column enabled by macro DATA_MEMORY_PARITY_EN.
module dmem_array
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int INDEX_BITS = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [INDEX_BITS-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_par_err
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  // data column: one word written per enabled cycle
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  assign o_rdata = r_mem[i_raddr];
`ifdef DATA_MEMORY_PARITY_EN
  logic r_par [DEPTH];
  // parity column tracks every data write, including clear writes
  always_ff @(posedge clk) begin
    if (i_we) r_par[i_waddr] <= ^i_wdata;
  end
  assign o_par_err = r_par[i_raddr] ^ (^o_rdata);
`else
  assign o_par_err = 1'b0;
`endif
endmodule

// File: rtl/data_memory.sv
// data_memory: cleared-on-reset word memory with range and optional parity checks.
// Macro DATA_MEMORY_PARITY_EN adds a stored parity bit per word and parity_err pulses.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_enable,
  input  logic                  store_enable,
  input  logic [ADDR_WIDTH-1:0] dmem_address,
  input  logic [DATA_WIDTH-1:0] dmem_dataIn,
  output logic [DATA_WIDTH-1:0] dmem_dataOut,
  output logic                  mem_ready,
  output logic                  range_err,
  output logic                  parity_err
);
  localparam int INDEX_BITS = $clog2(DEPTH);
  state_t                r_state;
  logic [INDEX_BITS-1:0] r_clr_idx;
  logic [INDEX_BITS-1:0] w_idx;
  logic                  w_oor;
  logic                  w_load;
  logic                  w_store;
  logic                  w_clearing;
  logic                  w_we;
  logic [INDEX_BITS-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_par_err;
  assign w_idx      = dmem_address[INDEX_BITS-1:0];
  assign w_oor      = |(dmem_address >> INDEX_BITS);
  assign w_clearing = (r_state == CLEAR);
  assign w_load     = !w_clearing && mem_enable && !store_enable;
  assign w_store    = !w_clearing && mem_enable && store_enable;
  // clearing owns the write port; otherwise only in-range stores write
  assign w_we    = w_clearing || (w_store && !w_oor);
  assign w_waddr = w_clearing ? r_clr_idx : w_idx;
  assign w_wdata = w_clearing ? '0 : dmem_dataIn;
  dmem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk      (clk),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_raddr  (w_idx),
    .o_rdata  (w_rdata),
    .o_par_err(w_par_err)
  );
  // clear sweep, request handling and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= CLEAR;
      r_clr_idx    <= '0;
      dmem_dataOut <= '0;
      mem_ready    <= 1'b0;
      range_err    <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      range_err  <= (w_load || w_store) && w_oor;
      parity_err <= w_load && !w_oor && w_par_err;
      if (w_load) dmem_dataOut <= w_oor ? '0 : w_rdata;
      if (w_clearing) begin
        r_clr_idx <= r_clr_idx + INDEX_BITS'(1);
        if (r_clr_idx == INDEX_BITS'(DEPTH - 1)) begin
          r_state   <= READY;
          mem_ready <= 1'b1;
        end
      end
    end
  end
endmodule
